// File: rtl/serial_cmd_rx_if.sv
// Pin and register-bus bundle between the FX2 serial host and serial_cmd_rx.
// Latency: none; this is wiring only.
// Backpressure: none; the host pins and the write strobe are fire-and-forget.
interface serial_cmd_rx_if;
    // Host pins, asynchronous to master_clk
    logic        serial_enable;
    logic        serial_clock;
    logic        serial_din;
    logic        serial_dout;

    // Readback sources
    logic [31:0] readback_0;
    logic [31:0] readback_1;
    logic [31:0] readback_2;
    logic [31:0] readback_3;

    // Register write bus
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        frame_error;

    // Receiver side
    modport slave (
        input  serial_enable,
        input  serial_clock,
        input  serial_din,
        output serial_dout,
        input  readback_0,
        input  readback_1,
        input  readback_2,
        input  readback_3,
        output serial_addr,
        output serial_data,
        output serial_strobe,
        output frame_error
    );

    // Host / register-file side
    modport master (
        output serial_enable,
        output serial_clock,
        output serial_din,
        input  serial_dout,
        output readback_0,
        output readback_1,
        output readback_2,
        output readback_3,
        input  serial_addr,
        input  serial_data,
        input  serial_strobe,
        frame_error
    );
endinterface

// File: rtl/serial_cmd_rx.sv
// Deserializes SEN/SCLK/SDI host frames into a one-cycle register write strobe; optional SDO readback.
// Latency: strobe/frame_error start on the 4th master_clk edge after SEN falls; SDO follows SCLK within 4 cycles.
// Backpressure: none; every accepted frame produces exactly one strobe or one error pulse.
// Readback is built only when SERIAL_READBACK_EN is defined; otherwise serial_dout is tied low.
module serial_cmd_rx #(
    parameter int FRAME_BITS = 40
) (
    input  logic            master_clk,
    input  logic            reset_n,
    serial_cmd_rx_if.slave  bus
);

    localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // Synchronizers: meta, sync, history
    logic r_sen_meta, r_sen_sync, r_sen_hist;
    logic r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic r_sdi_meta, r_sdi_sync;

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_sr;
    logic [5:0]              r_cnt;
    logic [6:0]              r_addr;
    logic [31:0]             r_data;
    logic                    r_strobe;
    logic                    r_ferr;

    logic                    w_sclk_rise;
    logic                    w_sen_fall;
    logic [FRAME_BITS-1:0]   w_sr_next;

    // Bring the host pins into master_clk. SEN resets high so that WAIT_IDLE
    // only leaves once a real low level has propagated through the chain.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sen_meta  <= 1'b1;
            r_sen_sync  <= 1'b1;
            r_sen_hist  <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_hist <= 1'b0;
            r_sdi_meta  <= 1'b0;
            r_sdi_sync  <= 1'b0;
        end else begin
            r_sen_meta  <= bus.serial_enable;
            r_sen_sync  <= r_sen_meta;
            r_sen_hist  <= r_sen_sync;
            r_sclk_meta <= bus.serial_clock;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_hist <= r_sclk_sync;
            r_sdi_meta  <= bus.serial_din;
            r_sdi_sync  <= r_sdi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_hist;
    assign w_sen_fall  = ~r_sen_sync & r_sen_hist;
    assign w_sr_next   = {r_sr[FRAME_BITS-2:0], r_sdi_sync};

    // Frame state machine: collect bits while SEN is high, then judge the frame
    // in DONE. IDLE tests the SEN level rather than the edge so that a SEN
    // re-rise landing during DONE is still caught.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_WAIT_IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            case (r_state)
                S_WAIT_IDLE: begin
                    if (!r_sen_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (r_sen_sync) begin
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_sr <= w_sr_next;
                        if (r_cnt != 6'd63) begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    if (w_sen_fall) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_cnt == FRAME_CNT) begin
                        // Read frames (MSB set) are consumed silently.
                        if (!r_sr[FRAME_BITS-1]) begin
                            r_addr   <= r_sr[FRAME_BITS-2 -: 7];
                            r_data   <= r_sr[31:0];
                            r_strobe <= 1'b1;
                        end
                    end else begin
                        r_ferr <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_WAIT_IDLE;
                end
            endcase
        end
    end

    assign bus.serial_addr   = r_addr;
    assign bus.serial_data   = r_data;
    assign bus.serial_strobe = r_strobe;
    assign bus.frame_error   = r_ferr;

`ifdef SERIAL_READBACK_EN
    logic        w_sclk_fall;
    logic [31:0] w_rb_sel;
    logic [31:0] r_rb_word;
    logic [4:0]  r_rb_cnt;
    logic        r_rb_act;
    logic        r_dout;

    assign w_sclk_fall = ~r_sclk_sync & r_sclk_hist;

    // Pick the readback word from the address that completes with the 8th bit.
    always_comb begin
        w_rb_sel = 32'h0;
        case (w_sr_next[6:0])
            7'd1:    w_rb_sel = bus.readback_0;
            7'd2:    w_rb_sel = bus.readback_1;
            7'd3:    w_rb_sel = bus.readback_2;
            7'd4:    w_rb_sel = bus.readback_3;
            default: w_rb_sel = 32'h0;
        endcase
    end

    // SDO shifter: latch on the 8th SCLK rise of a read, present the MSB at once,
    // advance one bit per SCLK fall, and go quiet after 32 bits or SEN fall.
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rb_word <= '0;
            r_rb_cnt  <= '0;
            r_rb_act  <= 1'b0;
            r_dout    <= 1'b0;
        end else if (r_state != S_SHIFT || w_sen_fall) begin
            r_rb_act <= 1'b0;
            r_dout   <= 1'b0;
        end else if (w_sclk_rise && r_cnt == 6'd7 && w_sr_next[7]) begin
            r_rb_word <= w_rb_sel;
            r_rb_cnt  <= '0;
            r_rb_act  <= 1'b1;
            r_dout    <= w_rb_sel[31];
        end else if (w_sclk_fall && r_rb_act) begin
            if (r_rb_cnt == 5'd31) begin
                r_rb_act <= 1'b0;
                r_dout   <= 1'b0;
            end else begin
                r_rb_word <= {r_rb_word[30:0], 1'b0};
                r_rb_cnt  <= r_rb_cnt + 5'd1;
                r_dout    <= r_rb_word[30];
            end
        end
    end

    assign bus.serial_dout = r_dout;
`else
    // Readback sources are not consumed in this build.
    logic w_unused_rb;
    assign w_unused_rb     = ^{bus.readback_0, bus.readback_1, bus.readback_2, bus.readback_3};
    assign bus.serial_dout = 1'b0;
`endif

endmodule

// File: doc/serial_cmd_rx.md
# serial_cmd_rx

- Deserializes host (FX2) serial commands into the `serial_addr` / `serial_data` / `serial_strobe` bus consumed by the setting registers and master control.
- Samples the asynchronous SEN/SCLK/SDI pins in the `master_clk` domain and assembles 40-bit frames.
- Issues a single-cycle write strobe per valid frame.
- Optionally serves register readback on SDO.

## Interface

Parameters:
- `FRAME_BITS`, default 40: bits per valid frame (1 R/W + 7 addr + 32 data).

Ports:
- `master_clk`  input  1  system clock; the only clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `serial_enable`  input  1  SEN pin, active-high frame enable; asynchronous to `master_clk`.
- `serial_clock`  input  1  SCLK pin; SDI is sampled on its rising edge; asynchronous.
- `serial_din`  input  1  SDI pin, MSB first.
- `serial_dout`  output  1  SDO pin, readback data.
- `readback_0`..`readback_3`  input  32 each  readback sources.
- `serial_addr`  output  7  address of the last accepted write.
- `serial_data`  output  32  data of the last accepted write.
- `serial_strobe`  output  1  one-cycle pulse per accepted write.
- `frame_error`  output  1  one-cycle pulse per discarded frame.

## Operation

Input synchronization:
- SEN, SCLK and SDI each pass through a 2-flop synchronizer, plus one history flop for edge detection.
- SCLK rise = sync=1, history=0. SEN fall = sync=0, history=1.

State machine:
- **WAIT_IDLE**
  - Entered from reset.
  - Moves to IDLE once synchronized SEN is seen low.
  - A frame already in progress at reset release is therefore ignored.
- **IDLE**
  - SEN rise → SHIFT.
  - On entry to SHIFT: clear the shift register and the bit counter.
- **SHIFT**
  - On each SCLK rise: shift register `{sr[38:0], SDI}`.
  - Bit counter is 6 bits and saturates at 63.
  - SEN fall → DONE.
- **DONE**, lasts one cycle, then IDLE:
  - count == 40 and `sr[39]`==0: register `serial_addr`=`sr[38:32]` and `serial_data`=`sr[31:0]`; pulse `serial_strobe`.
  - count != 40: pulse `frame_error`; outputs unchanged.
  - count == 40 and `sr[39]`==1 (read): no strobe and no error.

Readback (see Configuration):
- When count reaches 8 with `sr[7]`==1, latch a word selected by addr `sr[6:0]`:
  - addr 1 → `readback_0`
  - addr 2 → `readback_1`
  - addr 3 → `readback_2`
  - addr 4 → `readback_3`
  - any other addr → 32'h0
- `serial_dout` drives the word's MSB immediately.
- On each subsequent SCLK fall, the word shifts left and `serial_dout` takes the next bit.
- After 32 bits, or on SEN fall, `serial_dout` returns to 0.

Held values:
- `serial_addr` / `serial_data` hold until the next accepted write.
- `serial_dout` is 0 outside a read.

## Timing

- Reset values: `serial_addr`=0, `serial_data`=0, `serial_strobe`=0, `frame_error`=0, `serial_dout`=0; state=WAIT_IDLE.
- Pin requirements: SCLK high and low each ≥3 `master_clk` periods. SDI stable ≥3 periods around SCLK rise. SEN falls ≥3 periods after the last SCLK rise.
- Write latency: `serial_strobe` is high for exactly one cycle, starting on the 4th `master_clk` rising edge after the SEN falling edge. `serial_addr`/`serial_data` are valid in that same cycle.
- `frame_error` has the same timing as `serial_strobe`.
- SDO latency: `serial_dout` updates ≤4 `master_clk` cycles after the relevant SCLK edge.
- Back-to-back frames: SEN may re-rise 1 `master_clk` cycle after DONE; no frame is lost.
- SCLK edges while SEN is low are ignored.
- `reset_n` asserted mid-frame: outputs clear immediately. The partial frame is dropped and re-arming waits for SEN low.

## Configuration

Macro: `SERIAL_READBACK_EN`.
- **Defined:** readback path as described; `readback_*` inputs are used.
- **Undefined:**
  - `serial_dout` is tied to 0; no readback latch or SDO shifter is built; `readback_*` are unused.
  - Read frames are still silently ignored: no strobe and no error.

## Test plan

- Write frame, addr 7'h05, data 32'hDEADBEEF:
  - `serial_strobe` is high exactly 1 cycle, 4 edges after SEN fall.
  - `serial_addr`=5 and `serial_data`=DEADBEEF in that cycle, held afterwards.
- 39-bit frame, then 41-bit frame: `frame_error` pulses twice, no strobe, outputs keep their previous values.
- Read addr 3 with `readback_2`=32'hA5A5_0F0F, macro defined:
  - SDO returns A5A50F0F MSB first over 32 SCLK falls, then 0.
  - No strobe.
  - Macro undefined: SDO stays 0.
- Read addr 9 (macro defined): SDO returns 32'h0.
- `reset_n` pulsed after 20 bits of a write:
  - Outputs read 0; the remainder of that frame produces no strobe.
  - Next full write with addr 1, data 32'h1 is accepted.
- Two writes with SEN re-asserted 1 cycle after DONE: two strobes carrying the correct distinct addr/data.
